// File: rtl/ldpc_rd_agen.sv
// LDPC message-memory read-address generator: base+offset[k] (mod MEM_DEPTH) per beat, plus idle readout.
// Latency: beat 0 one cycle after start/out_en; back-to-back period N_OFF+1 with rd_ready high.
// Backpressure: rd_ready low stalls the current beat with all rd_* outputs held; optional LDPC_RD_SKIP_EN.
module ldpc_rd_agen #(
   parameter int A_WID     = 8,
   parameter int N_OFF     = 3,
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [A_WID-1:0]       base_addr,
   input  logic [N_OFF*A_WID-1:0] addr_offset,
   input  logic                   out_en,
   input  logic [A_WID-1:0]       out_addr,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [A_WID-1:0]       rd_addr,
   output logic [IDX_W-1:0]       rd_idx,
   output logic                   rd_src,
   output logic                   busy,
   output logic                   done
);

   localparam int SW = A_WID + 1;
   localparam logic [SW-1:0] DEPTH = SW'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t           state;
   logic [A_WID-1:0] base_q;
   logic [A_WID-1:0] off_in [N_OFF];
   logic [A_WID-1:0] off_q  [N_OFF];
   logic [N_OFF-1:0] null_in;
   logic [N_OFF-1:0] null_q;
   logic             first_fnd;
   logic             next_fnd;
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] next_idx;
   logic [A_WID-1:0] first_addr;
   logic [A_WID-1:0] next_addr;

   // Operands are always below MEM_DEPTH, so a single conditional subtract wraps the sum.
   function automatic logic [A_WID-1:0] wrap_add(input logic [A_WID-1:0] a,
                                                 input logic [A_WID-1:0] b);
      logic [SW-1:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= DEPTH) s = s - DEPTH;
      return s[A_WID-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < N_OFF; i++) begin
         off_in[i] = addr_offset[(N_OFF-i)*A_WID-1 -: A_WID];
      end
   end

   always_comb begin
      for (int i = 0; i < N_OFF; i++) begin
`ifdef LDPC_RD_SKIP_EN
         null_in[i] = (off_in[i] == '1);
         null_q[i]  = (off_q[i] == '1);
`else
         null_in[i] = 1'b0;
         null_q[i]  = 1'b0;
`endif
      end
   end

   // Lowest non-null index overall (for beat 0) and lowest one above the current beat.
   always_comb begin
      first_fnd  = 1'b0;
      first_idx  = '0;
      first_addr = '0;
      next_fnd   = 1'b0;
      next_idx   = '0;
      next_addr  = '0;
      for (int i = N_OFF-1; i >= 0; i--) begin
         if (!null_in[i]) begin
            first_fnd = 1'b1;
            first_idx = IDX_W'(i);
         end
         if (!null_q[i] && (IDX_W'(i) > rd_idx)) begin
            next_fnd = 1'b1;
            next_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < N_OFF; i++) begin
         if (IDX_W'(i) == first_idx) first_addr = wrap_add(base_addr, off_in[i]);
         if (IDX_W'(i) == next_idx)  next_addr  = wrap_add(base_q, off_q[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         base_q   <= '0;
         for (int i = 0; i < N_OFF; i++) off_q[i] <= '0;
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_idx   <= '0;
         rd_src   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  base_q <= base_addr;
                  for (int i = 0; i < N_OFF; i++) off_q[i] <= off_in[i];
                  rd_src   <= 1'b0;
                  rd_valid <= first_fnd;
                  rd_addr  <= first_fnd ? first_addr : '0;
                  rd_idx   <= first_fnd ? first_idx : '0;
               end else if (out_en) begin
                  state    <= OUT;
                  busy     <= 1'b1;
                  rd_valid <= 1'b1;
                  rd_addr  <= out_addr;
                  rd_idx   <= '0;
                  rd_src   <= 1'b1;
               end
            end
            RUN: begin
               // rd_valid low in RUN only happens when every offset was null.
               if (!rd_valid || (rd_ready && !next_fnd)) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  rd_valid <= 1'b0;
                  rd_addr  <= '0;
                  rd_idx   <= '0;
               end else if (rd_ready) begin
                  rd_addr <= next_addr;
                  rd_idx  <= next_idx;
               end
            end
            OUT: begin
               if (rd_ready) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  rd_valid <= 1'b0;
                  rd_addr  <= '0;
                  rd_src   <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               rd_valid <= 1'b0;
               rd_addr  <= '0;
               rd_idx   <= '0;
               rd_src   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_rd_agen.sv
// Directed bench for ldpc_rd_agen: default instance plus a MEM_DEPTH=200 instance for wrap boundaries.
module tb_ldpc_rd_agen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [23:0] addr_offset = '0;
   logic        out_en = 1'b0;
   logic [7:0]  out_addr = '0;
   logic        rd_ready = 1'b1;
   logic        rd_valid;
   logic [7:0]  rd_addr;
   logic [3:0]  rd_idx;
   logic        rd_src;
   logic        busy;
   logic        done;

   logic        start2 = 1'b0;
   logic [7:0]  base2 = '0;
   logic [15:0] off2 = '0;
   logic        out_en2 = 1'b0;
   logic [7:0]  out_addr2 = '0;
   logic        ready2 = 1'b1;
   logic        rd_valid2;
   logic [7:0]  rd_addr2;
   logic [3:0]  rd_idx2;
   logic        rd_src2;
   logic        busy2;
   logic        done2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ldpc_rd_agen dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .addr_offset(addr_offset), .out_en(out_en), .out_addr(out_addr),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_idx(rd_idx), .rd_src(rd_src), .busy(busy), .done(done)
   );

   ldpc_rd_agen #(.A_WID(8), .N_OFF(2), .MEM_DEPTH(200), .IDX_W(4)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(base2),
      .addr_offset(off2), .out_en(out_en2), .out_addr(out_addr2),
      .rd_ready(ready2), .rd_valid(rd_valid2), .rd_addr(rd_addr2),
      .rd_idx(rd_idx2), .rd_src(rd_src2), .busy(busy2), .done(done2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {valid, addr, idx, src, busy, done}
   task automatic expect_out(input string tag, input logic v, input logic [7:0] a,
                             input logic [3:0] k, input logic s, input logic b, input logic d);
      check({tag, ".valid"}, 32'(rd_valid), 32'(v));
      check({tag, ".addr"},  32'(rd_addr),  32'(a));
      check({tag, ".idx"},   32'(rd_idx),   32'(k));
      check({tag, ".src"},   32'(rd_src),   32'(s));
      check({tag, ".busy"},  32'(busy),     32'(b));
      check({tag, ".done"},  32'(done),     32'(d));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      #2;
      expect_out("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      expect_out("idle", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

      // basic sequence with wrap of 0x10+0xF0
      base_addr = 8'h10;
      addr_offset = {8'h05, 8'h20, 8'hF0};
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_out("b0", 1'b1, 8'h15, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b1", 1'b1, 8'h30, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2", 1'b1, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("done1", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

      // back-to-back start in the done cycle, with a 3-cycle stall on beat 1
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_out("s.b0", 1'b1, 8'h15, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      rd_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         expect_out($sformatf("s.hold%0d", c), 1'b1, 8'h30, 4'd1, 1'b0, 1'b1, 1'b0);
         tick();
      end
      rd_ready = 1'b1;
      expect_out("s.b1", 1'b1, 8'h30, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("s.b2", 1'b1, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("s.done", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
      tick();
      expect_out("s.idle", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

      // start beats out_en; inputs changing during RUN must not matter
      out_addr = 8'h7A;
      start = 1'b1;
      out_en = 1'b1;
      tick();
      start = 1'b0;
      out_en = 1'b0;
      base_addr = 8'h99;
      addr_offset = {8'h01, 8'h02, 8'h03};
      expect_out("p.b0", 1'b1, 8'h15, 4'd0, 1'b0, 1'b1, 1'b0);
      start = 1'b1;
      out_en = 1'b1;
      tick();
      expect_out("p.b1", 1'b1, 8'h30, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      start = 1'b0;
      out_en = 1'b0;
      expect_out("p.b2", 1'b1, 8'h00, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("p.done", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

      // readout beat, no done
      out_en = 1'b1;
      tick();
      out_en = 1'b0;
      expect_out("o.beat", 1'b1, 8'h7A, 4'd0, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("o.after", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

      // MEM_DEPTH=200 wrap boundaries: 150+60 -> 10, 150+49 -> 199
      base2 = 8'd150;
      off2 = {8'd60, 8'd49};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("d200.b0", 32'(rd_addr2), 32'd10);
      check("d200.v0", 32'(rd_valid2), 32'd1);
      tick();
      check("d200.b1", 32'(rd_addr2), 32'd199);
      check("d200.i1", 32'(rd_idx2), 32'd1);
      tick();
      check("d200.done", 32'(done2), 32'd1);

      // reset during beat 1
      base_addr = 8'h10;
      addr_offset = {8'h05, 8'h20, 8'hF0};
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      expect_out("r.b1", 1'b1, 8'h30, 4'd1, 1'b0, 1'b1, 1'b0);
      reset_n = 1'b0;
      #1;
      expect_out("r.async", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      expect_out("r.nodone", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_out("r.b0", 1'b1, 8'h15, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      expect_out("r.done", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

      // null offsets {FF,02,FF} at base 0x40
      base_addr = 8'h40;
      addr_offset = {8'hFF, 8'h02, 8'hFF};
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef LDPC_RD_SKIP_EN
      expect_out("k.b1", 1'b1, 8'h42, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("k.done", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
      addr_offset = {8'hFF, 8'hFF, 8'hFF};
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_out("k.null", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("k.ndone", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
`else
      expect_out("k.b0", 1'b1, 8'h3F, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("k.b1", 1'b1, 8'h42, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("k.b2", 1'b1, 8'h3F, 4'd2, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("k.done", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ldpc_rd_agen.md
# ldpc_rd_agen

Parametrised read-address generator for the LDPC decoder's message memory. On each `start` it latches a base address and a vector of `N_OFF` circulant offsets, then issues one read address per accepted beat (`base + offset[k]`, wrapped modulo `MEM_DEPTH`) over a valid/ready handshake. When idle it also serves single-beat output-readout requests (`out_en`/`out_addr`). It sits between the layer scheduler and the memory read port and replaces the fixed 3-offset, externally-cycled address cell.

## Interface
- `A_WID`, 8, address width in bits.
- `N_OFF`, 3, number of offsets per start (1..16).
- `MEM_DEPTH`, 256, memory depth; wrap modulus (2..2^A_WID).
- `IDX_W`, 4, width of `rd_idx`; must satisfy 2^IDX_W >= N_OFF.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `base_addr`  in  A_WID  base address, latched on accepted `start`.
- `addr_offset`  in  N_OFF*A_WID  offsets, latched on accepted `start`; slice k = `[(N_OFF-k)*A_WID-1 -: A_WID]`, so k=0 is the MS slice.
- `out_en`  in  1  output-readout request; accepted only in IDLE.
- `out_addr`  in  A_WID  readout address, latched on accepted `out_en`.
- `rd_ready`  in  1  memory port accepts the current beat.
- `rd_valid`  out  1  `rd_addr` is valid.
- `rd_addr`  out  A_WID  read address; 0 whenever `rd_valid`=0.
- `rd_idx`  out  IDX_W  offset index k of the current beat; 0 for readout beats.
- `rd_src`  out  1  0 = decode beat, 1 = readout beat.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse after a start sequence completes.

## Operation
- FSM states: IDLE, RUN, OUT.
- IDLE → RUN on `start`. `start` beats `out_en` when both are high in the same cycle; `out_en` is then dropped.
- IDLE → OUT on `out_en` with `start` low.
- `start` and `out_en` are ignored outside IDLE.
- RUN presents beat k with `rd_addr = wrap(base + offset[k])`, where wrap(s) = s − MEM_DEPTH if s ≥ MEM_DEPTH, else s. The sum is computed at A_WID+1 bits.
  - Inputs are guaranteed < MEM_DEPTH, so one subtraction always suffices.
- A beat transfers when `rd_valid && rd_ready`.
  - While stalled, `rd_addr`, `rd_idx` and `rd_src` hold stable.
  - On transfer, the next beat follows in the next cycle with no bubble.
- The transfer of beat N_OFF−1 moves RUN → IDLE. `done`=1 in the first IDLE cycle.
- OUT presents `out_addr` with `rd_src`=1. It returns to IDLE on transfer, and `done` stays 0.
- Latched `base_addr` and `addr_offset` are unaffected by input changes during RUN.

## Timing
- Reset: state IDLE; `rd_valid`, `rd_addr`, `rd_idx`, `rd_src`, `busy`, `done` all 0.
- All outputs are registered.
- `start` in cycle t: `busy`=1 and `rd_valid`=1 with beat 0 in cycle t+1.
- Total duration with `rd_ready` held high: N_OFF beats in cycles t+1..t+N_OFF, `done` in t+N_OFF+1.
- A new `start` is accepted in the `done` cycle, giving a back-to-back period of N_OFF+1 cycles.
- `out_en` in cycle t: readout beat in cycle t+1 (minimum).
- Reset asserted mid-sequence returns immediately to IDLE with all outputs 0. No `done` is issued.

## Configuration
- `LDPC_RD_SKIP_EN` defined:
  - An offset slice equal to all ones (2^A_WID−1) marks a null circulant. No beat is issued for it, and the next non-null index is presented in the same cycle the skipped one would have been.
  - A start whose offsets are all null goes IDLE → RUN → IDLE, with `rd_valid` never asserted and `done` in cycle t+2.
- Undefined: every slice is a real offset and all-ones is wrapped like any other value.

## Test plan
- Defaults, base=0x10, offsets {0x05,0x20,0xF0}, `rd_ready`=1 → `rd_addr` 0x15, 0x30, 0x00 (0x100 wrapped) with `rd_idx` 0,1,2 in cycles t+1..t+3; `done` at t+4.
- Same stimulus with `rd_ready` low for 3 cycles on beat 1 → 0x30 holds for 4 cycles, no beat lost or duplicated; `done` at t+7.
- `start` and `out_en` (out_addr=0x7A) in the same cycle → decode sequence only, no 0x7A beat. A later `out_en` in IDLE → `rd_addr`=0x7A, `rd_src`=1, no `done`.
- MEM_DEPTH=200, base=150, offset 60 → `rd_addr`=10. Offset 49 → 199.
- `reset_n` pulsed low during beat 1 → all outputs 0 asynchronously, no `done`. A new `start` after release runs from beat 0.
- With `LDPC_RD_SKIP_EN`, offsets {0xFF,0x02,0xFF}, base=0x40 → a single beat 0x42 with `rd_idx`=1 at t+1; `done` at t+2.
